valid_ready_rr_arbiter: RTL and testbench
=========================================

VALID_READY_RR_ARBITER -- requirements
Module: valid_ready_rr_arbiter

Interface
REQ-001 Parameter width, default 4, is the data bits per transfer.
REQ-002 Parameter n_req, default 4, is the number of upstream requesters; legal range is 2..8.
REQ-003 Parameter max_burst, default 2, is the maximum number of consecutive transfers granted to one requester while others wait; legal range is 1..15.
REQ-004 Port clk, input, 1 bit, is the single clock for the block.
REQ-005 Port rst, input, 1 bit, is the reset; it is asynchronous and active-high.
REQ-006 Port up_valid, input, n_req bits, is the per-requester valid.
REQ-007 Port up_ready, output, n_req bits, is the per-requester ready.
REQ-008 Port up_data, input, n_req*width bits, carries the data of requester i in bits [i*width +: width].
REQ-009 Port down_valid, output, 1 bit, is the merged-stream valid.
REQ-010 Port down_ready, input, 1 bit, is the merged-stream ready; it is typically the FIFO wrapper's up_ready.
REQ-011 Port down_data, output, width bits, is the merged-stream data.
REQ-012 Port down_id, output, $clog2(n_req) bits, is the index of the requester that produced down_data.

Function
REQ-013 A transfer occurs on a port in any cycle where its valid and ready are both 1 at the rising clk edge.
REQ-014 The output is one registered slot (down_valid/down_data/down_id); slot is "free" when down_valid=0 or down_ready=1.
REQ-015 up_ready[i] = free & grant[i], at most one bit set per cycle, combinational from down_ready, up_valid and state.
REQ-016 grant is one-hot among requesters with up_valid=1, chosen per REQ-017..019, or all-zero when up_valid=0.
REQ-017 Hold: if last winner L has up_valid[L]=1 and burst_cnt < max_burst, grant = L.
REQ-018 Otherwise grant = first i with up_valid[i]=1 scanning L+1, L+2, ... modulo n_req, ending at L.
REQ-019 After reset L = n_req-1, so requester 0 has first priority.
REQ-020 On an upstream transfer from i: down_data <= up_data[i], down_id <= i, down_valid <= 1, L <= i, and burst_cnt <= (i==L) ? burst_cnt+1 : 1.
REQ-021 On a downstream transfer with no upstream transfer in the same cycle: down_valid <= 0; down_data and down_id hold.
REQ-022 Simultaneous drain and load in one cycle is allowed; sustained throughput is 1 transfer/cycle.
REQ-023 Latency from upstream transfer to down_valid=1 is exactly 1 cycle.
REQ-024 While down_valid=1 and down_ready=0, down_data, down_id and down_valid hold stable and all up_ready=0.
REQ-025 If L drops up_valid, its burst ends; burst_cnt resets on the next grant to a different requester.
REQ-026 Only one requester valid: it is granted every free cycle regardless of burst_cnt, because the rotation returns to L.
REQ-027 burst_cnt saturates at max_burst and never wraps.
REQ-028 No output depends combinationally on any up_data; down_valid does not depend on down_ready.

Reset
REQ-029 While rst=1: down_valid=0, down_data=0, down_id=0, up_ready=0, L=n_req-1, burst_cnt=0.
REQ-030 Reset asserted mid-transfer discards the slot contents; no transfer is reported in that cycle.
REQ-031 After rst deasserts, the first grant is available in the same cycle (combinational up_ready).

Structure
REQ-032 Shared package valid_ready_arb_pkg holds the default n_req, width and max_burst constants.
REQ-033 Shared package valid_ready_arb_pkg holds the id-width localparam rule, $clog2(n_req).
REQ-034 Sub-module rr_select is purely combinational; it maps up_valid, L and the hold condition to one-hot grant and grant index.
REQ-035 State is held in the top module: L, burst_cnt and the output slot.
REQ-036 The block drops between the counter-driven sources and ff_fifo_wrapped_in_valid_ready on slow_clk.

Verification
REQ-037 All up_valid=1, down_ready=1, max_burst=2 -> down_id sequence 0,0,1,1,2,2,3,3,0 with one transfer per cycle.
REQ-038 up_valid=4'b0101, down_ready=1, max_burst=1 -> down_id alternates 0,2,0,2; up_ready[1] and up_ready[3] stay 0.
REQ-039 Slot full (data 4'hd, id 1), down_ready=0 for 5 cycles -> outputs stable; up_ready=0; one transfer when down_ready rises.
REQ-040 Only requester 3 valid for 6 cycles, max_burst=2 -> 6 consecutive transfers with down_id=3 (REQ-026).
REQ-041 rst pulsed while down_valid=1 with id 2 -> down_valid=0 next edge; first post-reset grant goes to requester 0 when all are valid.
REQ-042 Random valid/ready traffic vs a scoreboard -> no loss or duplication, per-requester order preserved, no requester starved beyond (n_req-1)*max_burst transfers.

Source files
------------

// File: rtl/valid_ready_arb_pkg.sv
// Shared constants and the id-width rule for the valid/ready round-robin arbiter.
package valid_ready_arb_pkg;

  localparam int DEFAULT_N_REQ     = 4;
  localparam int DEFAULT_WIDTH     = 4;
  localparam int DEFAULT_MAX_BURST = 2;
  localparam int BURST_CNT_W       = 4;

  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/valid_ready_rr_arbiter_rr_select.sv
// Combinational round-robin selector: keeps the last winner while it holds the
// burst, otherwise scans upward from last winner + 1, wrapping back to it.
module rr_select
  import valid_ready_arb_pkg::*;
#(
  parameter int n_req = DEFAULT_N_REQ,
  parameter int iw    = id_width(n_req)
) (
  input  logic [n_req-1:0] up_valid,
  input  logic [iw-1:0]    last_idx,
  input  logic             hold,
  output logic [n_req-1:0] grant,
  output logic [iw-1:0]    grant_idx
);

  logic found;
  int   j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    if (hold) begin
      grant[last_idx] = 1'b1;
      grant_idx       = last_idx;
    end else begin
      // Offset n_req lands back on the last winner, so a lone requester keeps winning.
      for (int k = 1; k <= n_req; k++) begin
        j = int'(last_idx) + k;
        if (j >= n_req) j = j - n_req;
        if (!found && up_valid[j]) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = iw'(j);
        end
      end
    end
  end

endmodule

// File: rtl/valid_ready_rr_arbiter.sv
// Merges n_req valid/ready streams into one registered output slot using
// round-robin arbitration with a bounded burst per winner.
module valid_ready_rr_arbiter
  import valid_ready_arb_pkg::*;
#(
  parameter int width     = DEFAULT_WIDTH,
  parameter int n_req     = DEFAULT_N_REQ,
  parameter int max_burst = DEFAULT_MAX_BURST
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [n_req-1:0]            up_valid,
  output logic [n_req-1:0]            up_ready,
  input  logic [n_req*width-1:0]      up_data,
  output logic                        down_valid,
  input  logic                        down_ready,
  output logic [width-1:0]            down_data,
  output logic [id_width(n_req)-1:0]  down_id
);

  localparam int iw = id_width(n_req);
  localparam logic [BURST_CNT_W-1:0] max_burst_c = BURST_CNT_W'(max_burst);
  localparam logic [BURST_CNT_W-1:0] one_c       = BURST_CNT_W'(1);
  localparam logic [iw-1:0]          last_rst_c  = iw'(n_req - 1);

  logic                   down_valid_q, down_valid_d;
  logic [width-1:0]       down_data_q,  down_data_d;
  logic [iw-1:0]          down_id_q,    down_id_d;
  logic [iw-1:0]          last_q,       last_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q,  burst_cnt_d;

  logic [n_req-1:0] grant;
  logic [iw-1:0]    grant_idx;
  logic             hold;
  logic             free;
  logic             up_xfer;
  logic [width-1:0] sel_data;

  // burst_cnt of 0 means no burst in progress, so after reset requester 0 wins first.
  assign hold = up_valid[last_q] && (burst_cnt_q != '0) && (burst_cnt_q < max_burst_c);

  rr_select #(
    .n_req (n_req),
    .iw    (iw)
  ) u_rr_select (
    .up_valid  (up_valid),
    .last_idx  (last_q),
    .hold      (hold),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign free     = !down_valid_q || down_ready;
  assign up_ready = (free && !rst) ? grant : '0;
  assign up_xfer  = |(up_valid & up_ready);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < n_req; i++) begin
      if (grant[i]) sel_data = up_data[i*width +: width];
    end
  end

  always_comb begin
    down_valid_d = down_valid_q;
    down_data_d  = down_data_q;
    down_id_d    = down_id_q;
    last_d       = last_q;
    burst_cnt_d  = burst_cnt_q;
    if (up_xfer) begin
      down_valid_d = 1'b1;
      down_data_d  = sel_data;
      down_id_d    = grant_idx;
      last_d       = grant_idx;
      if (grant_idx != last_q) burst_cnt_d = one_c;
      else if (burst_cnt_q < max_burst_c) burst_cnt_d = burst_cnt_q + one_c;
    end else if (down_valid_q && down_ready) begin
      down_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
      down_id_q    <= '0;
      last_q       <= last_rst_c;
      burst_cnt_q  <= '0;
    end else begin
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
      down_id_q    <= down_id_d;
      last_q       <= last_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;
  assign down_id    = down_id_q;

endmodule

// File: tb/tb_valid_ready_rr_arbiter.sv
// Directed vector table plus hand sequences and a random scoreboard run
// for the valid/ready round-robin arbiter.
module tb_valid_ready_rr_arbiter;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]   up_valid;
  logic [N*W-1:0] up_data;
  logic           down_ready;

  logic [N-1:0]  up_ready0, up_ready1;
  logic          down_valid0, down_valid1;
  logic [W-1:0]  down_data0, down_data1;
  logic [IW-1:0] down_id0, down_id1;

  valid_ready_rr_arbiter #(.width(W), .n_req(N), .max_burst(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready0),
    .up_data    (up_data),
    .down_valid (down_valid0),
    .down_ready (down_ready),
    .down_data  (down_data0),
    .down_id    (down_id0)
  );

  valid_ready_rr_arbiter #(.width(W), .n_req(N), .max_burst(1)) dut_b1 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready1),
    .up_data    (up_data),
    .down_valid (down_valid1),
    .down_ready (down_ready),
    .down_data  (down_data1),
    .down_id    (down_id1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  valid;
    logic          dr;
    logic [N-1:0]  exp_ready;
    logic          exp_dv;
    logic [IW-1:0] exp_id;
    logic [W-1:0]  exp_data;
  } vec_t;

  vec_t vecs[$];
  int vectors_applied = 0;
  int miscompares     = 0;

  logic [W-1:0]  seq[N];
  logic [W-1:0]  exp_seq[N];
  int            sent[N];
  int            rcvd[N];
  int            waitc[N];
  int            max_wait;
  logic [N-1:0]  pend;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic dr);
    up_valid   = v;
    down_ready = dr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void addVec(input logic [N-1:0] v, input logic dr, input logic [N-1:0] rdy,
                                 input logic dv, input logic [IW-1:0] id, input logic [W-1:0] d);
    vec_t t;
    t.valid = v; t.dr = dr; t.exp_ready = rdy; t.exp_dv = dv; t.exp_id = id; t.exp_data = d;
    vecs.push_back(t);
  endfunction

  // One random-traffic cycle: requesters hold valid and data until they transfer.
  task automatic doRandomCycle(input bit allow_new, input bit force_ready);
    logic [N-1:0] upx;
    down_ready = force_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
    for (int i = 0; i < N; i++) begin
      if (allow_new && !pend[i] && ($urandom_range(0, 3) != 0)) begin
        pend[i] = 1'b1;
        up_data[i*W +: W] = seq[i];
      end
    end
    up_valid = pend;
    #2;
    upx = up_valid & up_ready0;
    checkOutput("rand_onehot", 32'($countones(upx) <= 1), 32'd1);
    if (down_valid0 && down_ready) begin
      checkOutput($sformatf("rand_data_id%0d", down_id0), 32'(down_data0), 32'(exp_seq[down_id0]));
      exp_seq[down_id0] = exp_seq[down_id0] + 1'b1;
      rcvd[down_id0]++;
    end
    for (int i = 0; i < N; i++) begin
      if (upx[i]) begin
        pend[i]  = 1'b0;
        seq[i]   = seq[i] + 1'b1;
        sent[i]++;
        waitc[i] = 0;
      end else if (up_valid[i] && (upx != '0)) begin
        waitc[i]++;
        if (waitc[i] > max_wait) max_wait = waitc[i];
      end
    end
    tick();
  endtask

  initial begin
    // req3=5, req2=C, req1=D, req0=A
    up_data = 16'h5CDA;
    addVec(4'hF, 1, 4'h1, 1, 0, 4'hA);
    addVec(4'hF, 1, 4'h1, 1, 0, 4'hA);
    addVec(4'hF, 1, 4'h2, 1, 1, 4'hD);
    addVec(4'hF, 1, 4'h2, 1, 1, 4'hD);
    addVec(4'hF, 1, 4'h4, 1, 2, 4'hC);
    addVec(4'hF, 1, 4'h4, 1, 2, 4'hC);
    addVec(4'hF, 1, 4'h8, 1, 3, 4'h5);
    addVec(4'hF, 1, 4'h8, 1, 3, 4'h5);
    addVec(4'hF, 1, 4'h1, 1, 0, 4'hA);
    addVec(4'h2, 1, 4'h2, 1, 1, 4'hD);
    for (int k = 0; k < 5; k++) addVec(4'h2, 0, 4'h0, 1, 1, 4'hD);
    addVec(4'h0, 1, 4'h0, 0, 1, 4'hD);
    addVec(4'h0, 1, 4'h0, 0, 1, 4'hD);
    for (int k = 0; k < 6; k++) addVec(4'h8, 1, 4'h8, 1, 3, 4'h5);
    addVec(4'h0, 1, 4'h0, 0, 3, 4'h5);
    addVec(4'h4, 0, 4'h4, 1, 2, 4'hC);
    addVec(4'h4, 0, 4'h0, 1, 2, 4'hC);
    addVec(4'h3, 1, 4'h1, 1, 0, 4'hA);
    addVec(4'h3, 1, 4'h1, 1, 0, 4'hA);
    addVec(4'h3, 1, 4'h2, 1, 1, 4'hD);
    addVec(4'h1, 1, 4'h1, 1, 0, 4'hA);
    addVec(4'h4, 1, 4'h4, 1, 2, 4'hC);

    rst = 1'b1;
    applyStimulus(4'hF, 1'b1);
    #2;
    checkOutput("reset_down_valid", 32'(down_valid0), 32'd0);
    checkOutput("reset_down_data",  32'(down_data0),  32'd0);
    checkOutput("reset_down_id",    32'(down_id0),    32'd0);
    checkOutput("reset_up_ready",   32'(up_ready0),   32'd0);
    tick();
    rst = 1'b0;

    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].valid, vecs[v].dr);
      #1;
      checkOutput($sformatf("v%0d_up_ready", v), 32'(up_ready0), 32'(vecs[v].exp_ready));
      tick();
      checkOutput($sformatf("v%0d_down_valid", v), 32'(down_valid0), 32'(vecs[v].exp_dv));
      checkOutput($sformatf("v%0d_down_id", v),    32'(down_id0),    32'(vecs[v].exp_id));
      checkOutput($sformatf("v%0d_down_data", v),  32'(down_data0),  32'(vecs[v].exp_data));
    end

    // Reset while the slot holds id 2 and is stalled.
    applyStimulus(4'hF, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_down_valid", 32'(down_valid0), 32'd0);
    checkOutput("midrst_down_id",    32'(down_id0),    32'd0);
    checkOutput("midrst_down_data",  32'(down_data0),  32'd0);
    checkOutput("midrst_up_ready",   32'(up_ready0),   32'd0);
    tick();
    checkOutput("midrst_hold_valid", 32'(down_valid0), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("postrst_up_ready", 32'(up_ready0), 32'h1);
    tick();
    checkOutput("postrst_down_valid", 32'(down_valid0), 32'd1);
    checkOutput("postrst_down_id",    32'(down_id0),    32'd0);
    checkOutput("postrst_down_data",  32'(down_data0),  32'hA);

    // max_burst=1 instance alternates between requesters 0 and 2.
    rst = 1'b1;
    applyStimulus(4'h5, 1'b1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("b1_up_ready_%0d", k), 32'(up_ready1), (k % 2 == 0) ? 32'h1 : 32'h4);
      tick();
      checkOutput($sformatf("b1_down_id_%0d", k),    32'(down_id1),    (k % 2 == 0) ? 32'd0 : 32'd2);
      checkOutput($sformatf("b1_down_valid_%0d", k), 32'(down_valid1), 32'd1);
    end

    rst = 1'b1;
    applyStimulus(4'h0, 1'b0);
    pend = '0;
    max_wait = 0;
    for (int i = 0; i < N; i++) begin
      seq[i] = W'(i * 3); exp_seq[i] = W'(i * 3); sent[i] = 0; rcvd[i] = 0; waitc[i] = 0;
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 1500; c++) doRandomCycle(1'b1, 1'b0);
    for (int c = 0; c < 40 && (pend != '0 || down_valid0); c++) doRandomCycle(1'b0, 1'b1);
    checkOutput("drain_pending",    32'(pend),        32'd0);
    checkOutput("drain_down_valid", 32'(down_valid0), 32'd0);
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("rand_count_req%0d", i), 32'(rcvd[i]), 32'(sent[i]));
    checkOutput("starvation_bound", 32'(max_wait <= (N - 1) * 2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
